result_writer: RTL and testbench

Write-side controller for the result RAM (`dram`) that the VGA controller scans out. It accepts a processed 8-bit pixel stream over a valid/ready handshake and writes it into one 128×128 tile of the 512×512 result image. The target tile is selected by the same 5-bit `quadrant` index the display path uses. The block sits between the processing datapath and the `dram` write port, in the `clock_50` domain.

---
 rtl/vga_pkg.sv | 22 ++
 rtl/tile_addr_gen.sv | 72 +++++++
 rtl/result_writer.sv | 126 ++++++++++++
 tb/tb_result_writer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the result image tile map.
// The display controller imports the same values so both ends agree on
// where each 128x128 tile lives inside the 512x512 result RAM.
package vga_pkg;

    // Result image geometry; IMG_W is also the row stride in the RAM.
    localparam int IMG_W  = 512;
    localparam int TILE_W = 128;
    localparam int TILE_H = 128;
    localparam int ADDR_W = 18;

    // A 4x4 grid of tiles; quadrant indices at or above this are rejected.
    localparam int NUM_TILES = 16;

    // Write-side controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } writer_state_t;

endpackage : vga_pkg

// File: rtl/tile_addr_gen.sv
// Tile address generator: turns a tile index into a base address, then
// walks the tile row by row, one pixel per advance. The address is built
// incrementally (+1 per pixel, +row step at the end of each tile row),
// so no multiplier sits in the per-pixel path.
module tile_addr_gen #(
    parameter int IMG_W  = vga_pkg::IMG_W,
    parameter int TILE_W = vga_pkg::TILE_W,
    parameter int TILE_H = vga_pkg::TILE_H,
    parameter int ADDR_W = vga_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,      // start a new tile at tile_sel
    input  logic [3:0]        tile_sel,  // [3:2] tile row, [1:0] tile column
    input  logic              advance,   // current pixel consumed, step on
    output logic [ADDR_W-1:0] addr,      // address of the current pixel
    output logic              last       // current pixel is the tile's last
);

    localparam int COL_W = $clog2(TILE_W);
    localparam int ROW_W = $clog2(TILE_H);

    // One full band of tile rows in the RAM, and the jump from the end of
    // one tile row to the start of the next.
    localparam logic [ADDR_W-1:0] TILE_ROW_SPAN = ADDR_W'(TILE_H * IMG_W);
    localparam logic [ADDR_W-1:0] TILE_COL_SPAN = ADDR_W'(TILE_W);
    localparam logic [ADDR_W-1:0] ROW_STEP      = ADDR_W'(IMG_W - TILE_W + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(TILE_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TILE_H - 1);

    logic [COL_W-1:0]  col_cnt;
    logic [ROW_W-1:0]  row_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] base;
    logic              row_end;

    // Tile origin; the constant factors are powers of two for the default
    // geometry and only matter on load, never per pixel.
    assign base = ADDR_W'(tile_sel[3:2]) * TILE_ROW_SPAN
                + ADDR_W'(tile_sel[1:0]) * TILE_COL_SPAN;

    assign row_end = (col_cnt == COL_LAST);
    assign last    = row_end && (row_cnt == ROW_LAST);
    assign addr    = addr_q;

    // Position counters and running address: reload on a new tile, step on
    // each consumed pixel, wrapping the column at the end of a tile row.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_cnt <= '0;
            row_cnt <= '0;
            addr_q  <= '0;
        end else if (load) begin
            col_cnt <= '0;
            row_cnt <= '0;
            addr_q  <= base;
        end else if (advance) begin
            if (row_end) begin
                col_cnt <= '0;
                row_cnt <= row_cnt + 1'b1;
                addr_q  <= addr_q + ROW_STEP;
            end else begin
                col_cnt <= col_cnt + 1'b1;
                addr_q  <= addr_q + ADDR_W'(1);
            end
        end
    end

endmodule : tile_addr_gen

// File: rtl/result_writer.sv
// Write-side controller for the result RAM. Accepts a pixel stream over a
// valid/ready handshake and writes one tile of the result image, selected
// by the same quadrant index the display path uses. Writes are registered
// one cycle behind the accept; the last write coincides with done.
module result_writer
    import vga_pkg::*;
#(
    parameter int IMG_W  = vga_pkg::IMG_W,
    parameter int TILE_W = vga_pkg::TILE_W,
    parameter int TILE_H = vga_pkg::TILE_H,
    parameter int ADDR_W = vga_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        quadrant,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_address,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

    writer_state_t     state_q;
    writer_state_t     state_d;

    logic              idle;
    logic              quadrant_ok;
    logic              start_ok;
    logic              start_bad;
    logic              accept;
    logic              last_pixel;
    logic [ADDR_W-1:0] pixel_addr;

    assign idle        = (state_q == IDLE);
    assign quadrant_ok = (quadrant < 5'(NUM_TILES));

    // start is only looked at in IDLE, which is what makes it ignored
    // while busy.
    assign start_ok  = idle && start && quadrant_ok;
    assign start_bad = idle && start && !quadrant_ok;

    // Status outputs are plain decodes of the state register, so they
    // change only on a clock edge (or immediately on reset).
    assign in_ready = (state_q == WRITE);
    assign busy     = !idle;
    assign done     = (state_q == DONE);

    assign accept = in_valid && in_ready;

    tile_addr_gen #(
        .IMG_W  (IMG_W),
        .TILE_W (TILE_W),
        .TILE_H (TILE_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clock    (clock),
        .reset    (reset),
        .load     (start_ok),
        .tile_sel (quadrant[3:0]),
        .advance  (accept),
        .addr     (pixel_addr),
        .last     (last_pixel)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort wins over the last-pixel transition.
    // NOTE: state_d gets its default before the case so every path assigns
    // it and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept && last_pixel) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM write port and error pulse, registered from the accept / start
    // cycle. A pixel accepted in an abort cycle is still written, since
    // accept does not look at abort.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_en      <= 1'b0;
            wr_address <= '0;
            wr_data    <= '0;
            error      <= 1'b0;
        end else begin
            wr_en <= accept;
            error <= start_bad;
            if (accept) begin
                wr_address <= pixel_addr;
                wr_data    <= in_data;
            end
        end
    end

endmodule : result_writer

// File: tb/tb_result_writer.sv
// Self-checking bench for result_writer: a table of full-tile and error
// vectors plus hand-written sequences for gaps, abort and reset mid-tile.
`timescale 1ns/1ps
module tb_result_writer;
    import vga_pkg::*;

    localparam int AW        = ADDR_W;
    localparam int TILE_PIX  = TILE_W * TILE_H;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [4:0]    quadrant;
    logic          abort;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_address;
    logic [7:0]    wr_data;
    logic          busy;
    logic          done;
    logic          error;

    result_writer dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .quadrant   (quadrant),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_address (wr_address),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // ---------------- write monitor ----------------
    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_rec_t;

    wr_rec_t       wr_log[$];
    int            done_cnt;
    int            done_wr_cnt;
    int            err_cnt;
    logic [AW-1:0] done_addr;

    always @(negedge clock) begin
        if (wr_en) wr_log.push_back('{addr: wr_address, data: wr_data});
        if (done) begin
            done_cnt++;
            if (wr_en) done_wr_cnt++;
            done_addr = wr_address;
        end
        if (error) err_cnt++;
    end

    task automatic clear_mon();
        wr_log.delete();
        done_cnt    = 0;
        done_wr_cnt = 0;
        err_cnt     = 0;
        done_addr   = '0;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [AW-1:0] exp_addr(input int q, input int i);
        int base;
        base = (q / 4) * TILE_H * IMG_W + (q % 4) * TILE_W;
        return AW'(base + (i / TILE_W) * IMG_W + (i % TILE_W));
    endfunction

    function automatic logic [7:0] pix(input int q, input int i);
        return 8'(i * 7 + q * 13);
    endfunction

    // Compare the whole logged write sequence against the model.
    task automatic check_sequence(input string name, input int q, input int n);
        int mism = 0;
        int lim;
        lim = (wr_log.size() < n) ? wr_log.size() : n;
        for (int i = 0; i < lim; i++) begin
            if (wr_log[i].addr !== exp_addr(q, i) || wr_log[i].data !== pix(q, i))
                mism++;
        end
        check({name, "_count"}, wr_log.size(), n);
        check({name, "_seq"}, mism, 0);
    endtask

    // ---------------- drivers (all at negedge) ----------------
    task automatic do_start(input logic [4:0] q);
        @(negedge clock);
        start    = 1'b1;
        quadrant = q;
        @(negedge clock);
        start    = 1'b0;
    endtask

    // Push n pixels of tile q; optional random gaps and a stray start.
    task automatic drive_tile(input int q, input int n, input bit gaps,
                              input int stray_start_at, output int sent);
        int  cycles = 0;
        bit  v;
        bit  acc;
        sent = 0;
        while (sent < n && cycles < n * 4 + 200) begin
            v        = gaps ? ($urandom_range(0, 7) != 0) : 1'b1;
            in_valid = v;
            in_data  = pix(q, sent);
            start    = (cycles == stray_start_at);
            if (cycles == stray_start_at) quadrant = 5'd9;
            acc      = v && in_ready;
            @(posedge clock);
            if (acc) sent++;
            cycles++;
            @(negedge clock);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("drive_budget", sent, n);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [4:0]    q;
        logic          exp_err;
        logic [AW-1:0] exp_first;
        logic [AW-1:0] exp_128;
        logic [AW-1:0] exp_129;
        logic [AW-1:0] exp_last;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;

        vecs[0] = '{5'd0,  1'b0, 18'h00000, 18'h0007F, 18'h00200, 18'h0FE7F};
        vecs[1] = '{5'd5,  1'b0, 18'h10080, 18'h100FF, 18'h10280, 18'h1FEFF};
        vecs[2] = '{5'd15, 1'b0, 18'h30180, 18'h301FF, 18'h30380, 18'h3FFFF};
        vecs[3] = '{5'd20, 1'b1, 18'h0,     18'h0,     18'h0,     18'h0};
        vecs[4] = '{5'd31, 1'b1, 18'h0,     18'h0,     18'h0,     18'h0};

        reset    = 1'b1;
        start    = 1'b0;
        quadrant = '0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        clear_mon();

        repeat (3) @(negedge clock);
        check("reset_outputs",
              {in_ready, wr_en, wr_address, wr_data, busy, done, error}, 0);
        reset = 1'b0;
        @(negedge clock);

        // Table: full tiles with back-to-back valid, and invalid quadrants.
        for (int k = 0; k < 5; k++) begin
            clear_mon();
            do_start(vecs[k].q);
            if (vecs[k].exp_err) begin
                check("err_pulse", error, 1'b1);
                check("err_busy", busy, 1'b0);
                check("err_ready", in_ready, 1'b0);
                repeat (3) @(negedge clock);
                check("err_once", err_cnt, 1);
                check("err_no_write", wr_log.size(), 0);
                check("err_idle", busy, 1'b0);
            end else begin
                check("ready_rise", in_ready, 1'b1);
                drive_tile(vecs[k].q, TILE_PIX, 1'b0, -1, sent);
                check("ready_fall", in_ready, 1'b0);
                check("done_busy", busy, 1'b1);
                check("done_high", done, 1'b1);
                @(negedge clock);
                check("back_idle", {busy, done}, 2'b00);
                check_sequence("tile", vecs[k].q, TILE_PIX);
                if (wr_log.size() == TILE_PIX) begin
                    check("first_addr", wr_log[0].addr, vecs[k].exp_first);
                    check("addr_128", wr_log[127].addr, vecs[k].exp_128);
                    check("addr_129", wr_log[128].addr, vecs[k].exp_129);
                    check("last_addr", wr_log[TILE_PIX-1].addr, vecs[k].exp_last);
                end
                check("done_once", done_cnt, 1);
                check("done_with_last", done_wr_cnt, 1);
                check("done_addr", done_addr, vecs[k].exp_last);
            end
        end

        // Random gaps with a stray start in the middle of the tile.
        clear_mon();
        do_start(5'd3);
        drive_tile(3, TILE_PIX, 1'b1, 5000, sent);
        @(negedge clock);
        check_sequence("gaps", 3, TILE_PIX);
        check("gaps_done", done_cnt, 1);
        check("gaps_idle", busy, 1'b0);

        // Abort after 300 pixels, with a pixel accepted in the abort cycle.
        clear_mon();
        do_start(5'd2);
        drive_tile(2, 300, 1'b0, -1, sent);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = pix(2, 300);
        @(posedge clock);
        @(negedge clock);
        abort = 1'b0;
        check("abort_ready", in_ready, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_last_wr", wr_en, 1'b1);
        check("abort_last_addr", wr_address, exp_addr(2, 300));
        repeat (4) @(negedge clock);
        in_valid = 1'b0;
        check_sequence("abort", 2, 301);
        check("abort_no_done", done_cnt, 0);

        // Reset asserted mid-tile while a write is in flight.
        clear_mon();
        do_start(5'd1);
        drive_tile(1, 50, 1'b0, -1, sent);
        in_valid = 1'b1;
        in_data  = pix(1, 50);
        reset    = 1'b1;
        #1;
        check("midreset_outputs",
              {in_ready, wr_en, wr_address, wr_data, busy, done, error}, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("postreset_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        check_sequence("reset_run", 1, 50);
        check("reset_no_done", done_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_result_writer
